div32_seq: RTL and testbench

//  Iterative restoring divider, the inverse of the MULT32/MULT32_U multipliers.

---
 rtl/div32_seq.sv | 146 ++++++++++++++
 tb/tb_div32_seq.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/div32_seq.sv
// div32_seq: iterative restoring divider (signed DIV / unsigned DIVU), one quotient bit per cycle.
// Latency: START accepted in cycle 0 -> DONE pulse in cycle WIDTH+2 (cycle 2 for B==0 when
//   DIV_FAST_ZERO_EN is defined). Backpressure: none; START is only sampled in IDLE, never queued.
// Ports: i_clk, i_rst_n (async active-low), i_start, i_signed, i_a (dividend), i_b (divisor)
//   -> o_busy (RUN..FIX), o_done (1-cycle pulse), o_q, o_r, o_dz (held until next accepted START).
// Optional build macro: DIV_FAST_ZERO_EN -- divide-by-zero skips the RUN iterations.
module div32_seq #(
  parameter int WIDTH = 32
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic             i_signed,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_q,
  output logic [WIDTH-1:0] o_r,
  output logic             o_dz
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX, S_DONE} state_t;

  state_t           r_state;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_rem;    // partial remainder, always < divisor between steps
  logic [WIDTH-1:0] r_dvd;    // dividend bits shift out the top, quotient bits shift in
  logic [WIDTH-1:0] r_dvs;    // |B|; 0x8000_0000 stays as an unsigned magnitude
  logic [WIDTH-1:0] r_a;      // original dividend, returned as remainder on divide-by-zero
  logic             r_qneg;
  logic             r_rneg;
  logic             r_bz;
  logic             r_busy;
  logic             r_done;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_r;
  logic             r_dz;

  logic [WIDTH-1:0] w_a_abs;
  logic [WIDTH-1:0] w_b_abs;
  logic             w_b_zero;
  logic [WIDTH:0]   w_rem_sh;
  logic [WIDTH:0]   w_diff;
  logic             w_ge;
  logic [WIDTH-1:0] w_q_fix;
  logic [WIDTH-1:0] w_r_fix;

  assign w_a_abs  = (i_signed && i_a[WIDTH-1]) ? -i_a : i_a;
  assign w_b_abs  = (i_signed && i_b[WIDTH-1]) ? -i_b : i_b;
  assign w_b_zero = (i_b == '0);

  // The WIDTH+1-bit shifted remainder is below 2*divisor, so the sign bit of the
  // WIDTH+1-bit difference is an exact "remainder >= divisor" test.
  assign w_rem_sh = {r_rem, r_dvd[WIDTH-1]};
  assign w_diff   = w_rem_sh - {1'b0, r_dvs};
  assign w_ge     = ~w_diff[WIDTH];

  assign w_q_fix  = r_qneg ? -r_dvd : r_dvd;
  assign w_r_fix  = r_rneg ? -r_rem : r_rem;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_rem   <= '0;
      r_dvd   <= '0;
      r_dvs   <= '0;
      r_a     <= '0;
      r_qneg  <= 1'b0;
      r_rneg  <= 1'b0;
      r_bz    <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_q     <= '0;
      r_r     <= '0;
      r_dz    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (i_start) begin
            r_a    <= i_a;
            r_dvd  <= w_a_abs;
            r_dvs  <= w_b_abs;
            r_qneg <= i_signed & (i_a[WIDTH-1] ^ i_b[WIDTH-1]);
            r_rneg <= i_signed & i_a[WIDTH-1];
            r_bz   <= w_b_zero;
            r_rem  <= '0;
            r_cnt  <= CW'(WIDTH);
            r_q    <= '0;
            r_r    <= '0;
            r_dz   <= 1'b0;
            r_busy <= 1'b1;
`ifdef DIV_FAST_ZERO_EN
            r_state <= w_b_zero ? S_FIX : S_RUN;
`else
            r_state <= S_RUN;
`endif
          end
        end
        S_RUN: begin
          r_rem <= w_ge ? w_diff[WIDTH-1:0] : w_rem_sh[WIDTH-1:0];
          r_dvd <= {r_dvd[WIDTH-2:0], w_ge};
          r_cnt <= r_cnt - 1'b1;
          if (r_cnt == CW'(1)) begin
            r_state <= S_FIX;
          end
        end
        S_FIX: begin
          // Divide-by-zero overrides the iterated result in both builds.
          if (r_bz) begin
            r_q  <= '1;
            r_r  <= r_a;
            r_dz <= 1'b1;
          end else begin
            r_q  <= w_q_fix;
            r_r  <= w_r_fix;
            r_dz <= 1'b0;
          end
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
          r_state <= S_DONE;
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign o_busy = r_busy;
  assign o_done = r_done;
  assign o_q    = r_q;
  assign o_r    = r_r;
  assign o_dz   = r_dz;

endmodule

// File: tb/tb_div32_seq.sv
// tb_div32_seq: directed-vector bench for div32_seq with hand-computed results.
// Latency: checks DONE cycle index relative to the START cycle.
// Backpressure: exercises START held through RUN and back-to-back acceptance.
module tb_div32_seq;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        sgn;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [31:0] q;
  logic [31:0] r;
  logic        dz;

  int checks = 0;
  int errors = 0;

`ifdef DIV_FAST_ZERO_EN
  localparam int DZ_LAT = 2;
`else
  localparam int DZ_LAT = 34;
`endif

  div32_seq #(.WIDTH(32)) dut (
    .i_clk    (clk),
    .i_rst_n  (rst_n),
    .i_start  (start),
    .i_signed (sgn),
    .i_a      (a),
    .i_b      (b),
    .o_busy   (busy),
    .o_done   (done),
    .o_q      (q),
    .o_r      (r),
    .o_dz     (dz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Issue one op (START high for cycle 0 only), then check latency, busy, results and hold.
  task automatic run_op(input string tag, input logic s, input logic [31:0] av,
                        input logic [31:0] bv, input int lat, input logic [31:0] eq,
                        input logic [31:0] er, input logic edz);
    int cyc;
    @(negedge clk);
    start = 1'b1; sgn = s; a = av; b = bv;
    @(posedge clk);
    #1 start = 1'b0; sgn = ~s; a = ~av; b = ~bv;
    cyc = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) chk({tag, ".busy1"}, 32'(busy), 32'd1);
      if (done) break;
    end
    if (!done) cyc = -1;
    chk({tag, ".lat"}, 32'(cyc), 32'(lat));
    chk({tag, ".q"}, q, eq);
    chk({tag, ".r"}, r, er);
    chk({tag, ".dz"}, 32'(dz), 32'(edz));
    chk({tag, ".busy_done"}, 32'(busy), 32'd0);
    @(negedge clk);
    chk({tag, ".done_pulse"}, 32'(done), 32'd0);
    chk({tag, ".q_hold"}, q, eq);
  endtask

  initial begin
    int cyc;
    int ndone;
    rst_n = 1'b0; start = 1'b0; sgn = 1'b0; a = '0; b = '0;
    repeat (2) @(negedge clk);
    chk("rst.busy", 32'(busy), 32'd0);
    chk("rst.done", 32'(done), 32'd0);
    chk("rst.q", q, 32'd0);
    chk("rst.r", r, 32'd0);
    chk("rst.dz", 32'(dz), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    run_op("u100_7",   1'b0, 32'd100,       32'd7,         34, 32'd14,        32'd2,        1'b0);
    run_op("sm100_7",  1'b1, 32'hFFFF_FF9C, 32'd7,         34, 32'hFFFF_FFF2, 32'hFFFF_FFFE, 1'b0);
    run_op("s100_m7",  1'b1, 32'd100,       32'hFFFF_FFF9, 34, 32'hFFFF_FFF2, 32'd2,        1'b0);
    run_op("s_ovf",    1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 34, 32'h8000_0000, 32'd0,        1'b0);
    run_op("u_max_1",  1'b0, 32'hFFFF_FFFF, 32'd1,         34, 32'hFFFF_FFFF, 32'd0,        1'b0);
    run_op("u_msb",    1'b0, 32'hFFFF_FFFF, 32'h8000_0000, 34, 32'd1,         32'h7FFF_FFFF, 1'b0);
    run_op("s7_min",   1'b1, 32'd7,         32'h8000_0000, 34, 32'd0,         32'd7,        1'b0);
    run_op("u_dz",     1'b0, 32'h1234_5678, 32'd0,     DZ_LAT, 32'hFFFF_FFFF, 32'h1234_5678, 1'b1);
    run_op("s_dz",     1'b1, 32'h8000_0000, 32'd0,     DZ_LAT, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1);
    run_op("s_m1_2",   1'b1, 32'hFFFF_FFFF, 32'd2,         34, 32'd0,         32'hFFFF_FFFF, 1'b0);

    // START held high with changing operands through RUN: first result must be 100/7,
    // the held START is taken again in the IDLE cycle after DONE (now 9/3).
    @(negedge clk);
    start = 1'b1; sgn = 1'b0; a = 32'd100; b = 32'd7;
    @(posedge clk);
    #1 a = 32'd9; b = 32'd3;
    cyc = 0;
    ndone = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      cyc++;
      if (done) break;
    end
    chk("hold.lat", 32'(cyc), 32'd34);
    chk("hold.q", q, 32'd14);
    chk("hold.r", r, 32'd2);
    @(negedge clk);
    chk("hold.done_pulse", 32'(done), 32'd0);
    chk("hold.idle_busy", 32'(busy), 32'd0);
    @(posedge clk);
    #1 start = 1'b0;
    cyc = 35;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      cyc++;
      if (done) begin
        ndone++;
        break;
      end
    end
    chk("b2b.lat", 32'(cyc), 32'd69);
    chk("b2b.ndone", 32'(ndone), 32'd1);
    chk("b2b.q", q, 32'd3);
    chk("b2b.r", r, 32'd0);

    // Reset in the middle of an operation.
    @(negedge clk);
    start = 1'b1; sgn = 1'b0; a = 32'd100; b = 32'd7;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (10) @(negedge clk);
    chk("mid.busy_pre", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid.busy", 32'(busy), 32'd0);
    chk("mid.done", 32'(done), 32'd0);
    chk("mid.q", q, 32'd0);
    chk("mid.r", r, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    ndone = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    chk("mid.no_done", 32'(ndone), 32'd0);
    run_op("post_rst", 1'b0, 32'd9, 32'd3, 34, 32'd3, 32'd0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
